// File: rtl/clk_div_pkg.sv
// Shared types for the integer-ratio clock divider: output level state and phase-length helper.
`timescale 1ns/1ps
package clk_div_pkg;

   localparam int CLK_DIV_WIDTH_DEF = 8;

   typedef enum logic {
      LVL_LOW  = 1'b0,
      LVL_HIGH = 1'b1
   } lvl_e;

   // Odd ratios put the extra reference cycle in the LOW phase.
   function automatic int unsigned phase_len_f(input int unsigned ratio, input lvl_e lvl);
      int unsigned half;
      half = ratio >> 1;
      if (lvl == LVL_LOW)
         return half + (ratio & 32'd1);
      return half;
   endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Enable-gated phase counter; tc is asserted combinationally in the last cycle of a phase.
// Counter is held at zero while run is low; >= compare ends a phase early if len shrinks.
`timescale 1ns/1ps
module clk_div_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [WIDTH-1:0] len,
   output logic             tc
);

   logic [WIDTH-1:0] cnt;

   assign tc = run & (cnt >= (len - WIDTH'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (!run || tc)
         cnt <= '0;
      else
         cnt <= cnt + WIDTH'(1);
   end

endmodule

// File: rtl/clk_div.sv
// Integer-ratio clock divider; output is a registered toggle in divide mode, the reference clock otherwise.
// First rising edge of the divided clock lands on the ceil(N/2)-th reference edge after entering divide mode.
`timescale 1ns/1ps
module clk_div
   import clk_div_pkg::*;
#(
   parameter int WIDTH = CLK_DIV_WIDTH_DEF
) (
   input  logic             i_ref_clk,
   input  logic             i_rst,
   input  logic             i_clk_en,
   input  logic [WIDTH-1:0] i_div_ratio,
   output logic             o_div_clk
);

   logic             div_active;
   logic             tc;
   logic             div_tgl;
   lvl_e             div_lvl;
   logic [WIDTH-1:0] phase_len;

   assign div_active = i_clk_en & (i_div_ratio >= WIDTH'(2));
   assign phase_len  = WIDTH'(phase_len_f(32'(i_div_ratio), div_lvl));

   clk_div_cnt #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk (i_ref_clk),
      .rst (i_rst),
      .run (div_active),
      .len (phase_len),
      .tc  (tc)
   );

   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst)
         div_lvl <= LVL_LOW;
      else if (!div_active)
         div_lvl <= LVL_LOW;
      else if (tc)
         div_lvl <= (div_lvl == LVL_LOW) ? LVL_HIGH : LVL_LOW;
   end

   assign div_tgl = (div_lvl == LVL_HIGH);

   // Only combinational path from the reference clock to the output.
   assign o_div_clk = div_active ? div_tgl : i_ref_clk;

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div at WIDTH=3 with a 100 ns reference clock.
`timescale 1ns/1ps
module tb_clk_div;

   logic       ref_clk;
   logic       rst;
   logic       clk_en;
   logic [2:0] div_ratio;
   logic       div_clk;

   int errors = 0;
   int checks = 0;

   clk_div #(
      .WIDTH (3)
   ) dut (
      .i_ref_clk   (ref_clk),
      .i_rst       (rst),
      .i_clk_en    (clk_en),
      .i_div_ratio (div_ratio),
      .o_div_clk   (div_clk)
   );

   initial begin
      ref_clk = 1'b0;
      forever #50 ref_clk = ~ref_clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic edge_hi();
      @(posedge ref_clk);
      #10;
   endtask

   task automatic edge_lo();
      @(negedge ref_clk);
      #10;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      clk_en    = 1'b0;
      div_ratio = 3'd0;
      edge_hi();
      checks++;
      if (div_clk !== 1'b1) begin
         errors++;
         $display("FAIL reset_bypass_hi: div_clk=%b expected 1", div_clk);
      end
      checks++;
      if (dut.div_tgl !== 1'b0) begin
         errors++;
         $display("FAIL reset_flop: div_tgl=%b expected 0", dut.div_tgl);
      end
      edge_lo();
      checks++;
      if (div_clk !== 1'b0) begin
         errors++;
         $display("FAIL reset_bypass_lo: div_clk=%b expected 0", div_clk);
      end
   endtask

   task automatic test_enable_n4();
      logic exp [8];
      exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      rst       = 1'b0;
      div_ratio = 3'd4;
      clk_en    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         edge_hi();
         checks++;
         if (div_clk !== 1'b1) begin
            errors++;
            $display("FAIL en0_bypass_hi cycle %0d: div_clk=%b expected 1", i, div_clk);
         end
         edge_lo();
         checks++;
         if (div_clk !== 1'b0) begin
            errors++;
            $display("FAIL en0_bypass_lo cycle %0d: div_clk=%b expected 0", i, div_clk);
         end
      end
      clk_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         edge_hi();
         checks++;
         if (div_clk !== exp[i]) begin
            errors++;
            $display("FAIL n4 edge %0d: div_clk=%b expected %b", i + 1, div_clk, exp[i]);
         end
         edge_lo();
         checks++;
         if (div_clk !== exp[i]) begin
            errors++;
            $display("FAIL n4 hold %0d: div_clk=%b expected %b", i + 1, div_clk, exp[i]);
         end
      end
   endtask

   task automatic test_reset_odd();
      logic exp [10];
      exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      rst       = 1'b1;
      div_ratio = 3'd5;
      #1;
      checks++;
      if (dut.div_tgl !== 1'b0) begin
         errors++;
         $display("FAIL n5_reset_flop: div_tgl=%b expected 0", dut.div_tgl);
      end
      edge_hi();
      checks++;
      if (div_clk !== 1'b0) begin
         errors++;
         $display("FAIL n5_reset_out: div_clk=%b expected 0", div_clk);
      end
      edge_lo();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         edge_hi();
         checks++;
         if (div_clk !== exp[i]) begin
            errors++;
            $display("FAIL n5 edge %0d: div_clk=%b expected %b", i + 1, div_clk, exp[i]);
         end
         edge_lo();
         checks++;
         if (div_clk !== exp[i]) begin
            errors++;
            $display("FAIL n5 hold %0d: div_clk=%b expected %b", i + 1, div_clk, exp[i]);
         end
      end
   endtask

   task automatic test_ratio_change();
      logic exp6 [6];
      logic exp7 [7];
      exp6 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      exp7 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      div_ratio = 3'd6;
      for (int i = 0; i < 6; i++) begin
         edge_hi();
         checks++;
         if (div_clk !== exp6[i]) begin
            errors++;
            $display("FAIL n6 edge %0d: div_clk=%b expected %b", i + 1, div_clk, exp6[i]);
         end
         edge_lo();
      end
      div_ratio = 3'd7;
      for (int i = 0; i < 7; i++) begin
         edge_hi();
         checks++;
         if (div_clk !== exp7[i]) begin
            errors++;
            $display("FAIL n7 edge %0d: div_clk=%b expected %b", i + 1, div_clk, exp7[i]);
         end
         edge_lo();
      end
   endtask

   task automatic test_mid_phase_switch();
      logic exp_a [5];
      logic exp_b [5];
      exp_a = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_b = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      div_ratio = 3'd6;
      for (int i = 0; i < 5; i++) begin
         edge_hi();
         checks++;
         if (div_clk !== exp_a[i]) begin
            errors++;
            $display("FAIL n6_run edge %0d: div_clk=%b expected %b", i + 1, div_clk, exp_a[i]);
         end
         edge_lo();
      end
      checks++;
      if (dut.u_cnt.cnt !== 3'd2) begin
         errors++;
         $display("FAIL n6_mid_cnt: cnt=%0d expected 2", dut.u_cnt.cnt);
      end
      div_ratio = 3'd2;
      for (int i = 0; i < 5; i++) begin
         edge_hi();
         checks++;
         if (div_clk !== exp_b[i]) begin
            errors++;
            $display("FAIL n2_switch edge %0d: div_clk=%b expected %b", i + 1, div_clk, exp_b[i]);
         end
         edge_lo();
         checks++;
         if (div_clk !== exp_b[i]) begin
            errors++;
            $display("FAIL n2_switch hold %0d: div_clk=%b expected %b", i + 1, div_clk, exp_b[i]);
         end
      end
   endtask

   task automatic test_bypass_ratios();
      for (int r = 1; r >= 0; r--) begin
         div_ratio = 3'(r);
         clk_en    = 1'b1;
         edge_hi();
         checks++;
         if (div_clk !== 1'b1) begin
            errors++;
            $display("FAIL bypass_n%0d_hi: div_clk=%b expected 1", r, div_clk);
         end
         checks++;
         if (dut.div_tgl !== 1'b0) begin
            errors++;
            $display("FAIL bypass_n%0d_flop: div_tgl=%b expected 0", r, dut.div_tgl);
         end
         edge_lo();
         checks++;
         if (div_clk !== 1'b0) begin
            errors++;
            $display("FAIL bypass_n%0d_lo: div_clk=%b expected 0", r, div_clk);
         end
      end
   endtask

   task automatic test_disable_reenable();
      logic exp_a [3];
      logic exp_b [6];
      exp_a = '{1'b0, 1'b1, 1'b1};
      exp_b = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      div_ratio = 3'd4;
      clk_en    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         edge_hi();
         checks++;
         if (div_clk !== exp_a[i]) begin
            errors++;
            $display("FAIL pre_disable edge %0d: div_clk=%b expected %b", i + 1, div_clk, exp_a[i]);
         end
         edge_lo();
      end
      clk_en = 1'b0;
      #1;
      checks++;
      if (div_clk !== 1'b0) begin
         errors++;
         $display("FAIL disable_immediate: div_clk=%b expected 0", div_clk);
      end
      for (int i = 0; i < 2; i++) begin
         edge_hi();
         checks++;
         if (div_clk !== 1'b1) begin
            errors++;
            $display("FAIL disabled_hi cycle %0d: div_clk=%b expected 1", i, div_clk);
         end
         checks++;
         if (dut.div_tgl !== 1'b0 || dut.u_cnt.cnt !== 3'd0) begin
            errors++;
            $display("FAIL disabled_state cycle %0d: div_tgl=%b cnt=%0d expected 0/0", i, dut.div_tgl, dut.u_cnt.cnt);
         end
         edge_lo();
         checks++;
         if (div_clk !== 1'b0) begin
            errors++;
            $display("FAIL disabled_lo cycle %0d: div_clk=%b expected 0", i, div_clk);
         end
      end
      clk_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         edge_hi();
         checks++;
         if (div_clk !== exp_b[i]) begin
            errors++;
            $display("FAIL reenable edge %0d: div_clk=%b expected %b", i + 1, div_clk, exp_b[i]);
         end
         edge_lo();
      end
   endtask

   initial begin
      test_reset();
      test_enable_n4();
      test_reset_odd();
      test_ratio_change();
      test_mid_phase_switch();
      test_bypass_ratios();
      test_disable_reenable();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
